bus_transfer_controller: RTL and testbench

Sequencer that drives the register-file side of the shared 16-bit data bus. It accepts one register-to-register (or immediate-to-register) move request at a time. It then generates the one-hot output-enable of the source register's tri-state driver and the one-hot input-enable of the destination register, using a break-before-make sequence, and signals completion. It sits between the instruction decoder and the general-purpose registers.

---
 rtl/bus_transfer_controller.sv | 116 +++++++++++
 tb/tb_bus_transfer_controller.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_transfer_controller.sv
// Break-before-make move sequencer for the shared register-file bus.
// One request at a time: drive the source, then load the destination, then report completion.
module bus_transfer_controller #(
    parameter int NUM_REGS   = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  bus_clock,
    input  logic                  bus_reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_src,
    input  logic [2:0]            req_dst,
    input  logic                  req_imm_en,
    input  logic [DATA_WIDTH-1:0] req_imm,
    output logic [NUM_REGS-1:0]   reg_out_en,
    output logic [NUM_REGS-1:0]   reg_in_en,
    output logic                  imm_out_en,
    output logic [DATA_WIDTH-1:0] bus_imm_data,
    input  logic [DATA_WIDTH-1:0] bus_data,
    output logic [DATA_WIDTH-1:0] bus_sample,
    output logic                  xfer_done,
    output logic                  xfer_err
);

    typedef enum logic [1:0] {IDLE, DRIVE, LATCH, DONE} state_t;

    localparam logic [3:0]          REG_LIMIT = 4'(NUM_REGS);
    localparam logic [NUM_REGS-1:0] ONE_HOT0  = NUM_REGS'(1);

    state_t              state, state_n;
    logic [2:0]          src_q, src_n, dst_q, dst_n;
    logic                imm_en_q, imm_en_n, err_q, err_n;
    logic                accept, req_err;
    logic [NUM_REGS-1:0] out_en_n, in_en_n;
    logic                imm_out_n, done_n, xfer_err_n;

    assign req_ready = (state == IDLE);

    assign req_err = ({1'b0, req_dst} >= REG_LIMIT) ||
                     (!req_imm_en && (({1'b0, req_src} >= REG_LIMIT) || (req_src == req_dst)));

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_n    = state;
        src_n      = src_q;
        dst_n      = dst_q;
        imm_en_n   = imm_en_q;
        err_n      = err_q;
        accept     = 1'b0;
        out_en_n   = '0;
        in_en_n    = '0;
        imm_out_n  = 1'b0;
        done_n     = 1'b0;
        xfer_err_n = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept   = 1'b1;
                    src_n    = req_src;
                    dst_n    = req_dst;
                    imm_en_n = req_imm_en;
                    err_n    = req_err;
                    state_n  = req_err ? DONE : DRIVE;
                end
            end
            DRIVE:   state_n = LATCH;
            LATCH:   state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Enables are decoded from the state being entered so they leave a flop, not logic.
        if (state_n == DRIVE || state_n == LATCH) begin
            if (imm_en_n) imm_out_n = 1'b1;
            else          out_en_n  = ONE_HOT0 << src_n;
        end
        if (state_n == LATCH) in_en_n = ONE_HOT0 << dst_n;
        if (state_n == DONE) begin
            done_n     = 1'b1;
            xfer_err_n = err_n;
        end
    end

    // NOTE: state and outputs use non-blocking assignments; reset is synchronous and wins over a request.
    always_ff @(posedge bus_clock) begin
        if (!bus_reset_n) begin
            state        <= IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            imm_en_q     <= 1'b0;
            err_q        <= 1'b0;
            reg_out_en   <= '0;
            reg_in_en    <= '0;
            imm_out_en   <= 1'b0;
            bus_imm_data <= '0;
            bus_sample   <= '0;
            xfer_done    <= 1'b0;
            xfer_err     <= 1'b0;
        end else begin
            state      <= state_n;
            src_q      <= src_n;
            dst_q      <= dst_n;
            imm_en_q   <= imm_en_n;
            err_q      <= err_n;
            reg_out_en <= out_en_n;
            reg_in_en  <= in_en_n;
            imm_out_en <= imm_out_n;
            xfer_done  <= done_n;
            xfer_err   <= xfer_err_n;
            if (accept)         bus_imm_data <= req_imm;
            if (state == LATCH) bus_sample   <= bus_data;
        end
    end

endmodule

// File: tb/tb_bus_transfer_controller.sv
// Self-checking bench: transaction-age reference model compared every cycle, plus directed literal checks.
module tb_bus_transfer_controller;

    localparam int NR = 8;
    localparam int DW = 16;

    logic          bus_clock = 1'b0;
    logic          bus_reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [2:0]    req_src = '0, req_dst = '0;
    logic          req_imm_en = 1'b0;
    logic [DW-1:0] req_imm = '0, bus_data = '0;

    logic          req_ready, imm_out_en, xfer_done, xfer_err;
    logic [NR-1:0] reg_out_en, reg_in_en;
    logic [DW-1:0] bus_imm_data, bus_sample;

    logic          d4_ready, d4_imm_out_en, d4_done, d4_err;
    logic [3:0]    d4_out_en, d4_in_en;
    logic [DW-1:0] d4_imm_data, d4_sample;

    bus_transfer_controller #(.NUM_REGS(NR), .DATA_WIDTH(DW)) dut (
        .bus_clock(bus_clock), .bus_reset_n(bus_reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_dst(req_dst), .req_imm_en(req_imm_en), .req_imm(req_imm),
        .reg_out_en(reg_out_en), .reg_in_en(reg_in_en), .imm_out_en(imm_out_en),
        .bus_imm_data(bus_imm_data), .bus_data(bus_data), .bus_sample(bus_sample),
        .xfer_done(xfer_done), .xfer_err(xfer_err)
    );

    bus_transfer_controller #(.NUM_REGS(4), .DATA_WIDTH(DW)) dut4 (
        .bus_clock(bus_clock), .bus_reset_n(bus_reset_n),
        .req_valid(req_valid), .req_ready(d4_ready),
        .req_src(req_src), .req_dst(req_dst), .req_imm_en(req_imm_en), .req_imm(req_imm),
        .reg_out_en(d4_out_en), .reg_in_en(d4_in_en), .imm_out_en(d4_imm_out_en),
        .bus_imm_data(d4_imm_data), .bus_data(bus_data), .bus_sample(d4_sample),
        .xfer_done(d4_done), .xfer_err(d4_err)
    );

    always #5 bus_clock = ~bus_clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycles elapsed since the accepted request plus the request's contents.
    int            m_age = 0;
    bit            m_live = 1'b0;
    bit            m_err = 1'b0, m_imm_en = 1'b0;
    int            m_src = 0, m_dst = 0;
    logic [DW-1:0] m_imm = '0, m_sample = '0;
    int            m_accepts = 0;

    always @(posedge bus_clock) begin
        if (!bus_reset_n) begin
            m_age = 0; m_err = 1'b0; m_imm_en = 1'b0;
            m_imm = '0; m_sample = '0; m_live = 1'b1;
        end else if (m_live) begin
            if (m_age == 0) begin
                if (req_valid) begin
                    m_src    = int'(req_src);
                    m_dst    = int'(req_dst);
                    m_imm_en = req_imm_en;
                    m_imm    = req_imm;
                    m_err    = (m_dst >= NR) || (!m_imm_en && (m_src >= NR || m_src == m_dst));
                    m_age    = 1;
                    m_accepts++;
                end
            end else begin
                if (m_age == 2) m_sample = bus_data;
                if (m_err || m_age == 3) m_age = 0;
                else m_age++;
            end
        end
    end

    always @(posedge bus_clock) begin
        #2;
        if (m_live) begin
            bit driving;
            driving = !m_err && (m_age == 1 || m_age == 2);
            check("ready",    req_ready,  m_age == 0);
            check("out_en",   reg_out_en, (driving && !m_imm_en) ? (32'd1 << m_src) : 32'd0);
            check("imm_out",  imm_out_en, driving && m_imm_en);
            check("in_en",    reg_in_en,  (!m_err && m_age == 2) ? (32'd1 << m_dst) : 32'd0);
            check("done",     xfer_done,  (m_err && m_age == 1) || (!m_err && m_age == 3));
            check("err",      xfer_err,   m_err && m_age == 1);
            check("imm_data", bus_imm_data, m_imm);
            check("sample",   bus_sample, m_sample);
            check("inv_drivers", ($countones(reg_out_en) + int'(imm_out_en)) <= 1, 1);
            check("inv_in_needs_src", (reg_in_en == '0) || (reg_out_en != '0) || imm_out_en, 1);
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 16) begin
            @(negedge bus_clock);
            n++;
        end
        check("wait_ready", req_ready, 1);
    endtask

    task automatic request(input logic [2:0] src, input logic [2:0] dst,
                           input logic imm_en, input logic [DW-1:0] imm);
        req_src = src; req_dst = dst; req_imm_en = imm_en; req_imm = imm; req_valid = 1'b1;
        @(negedge bus_clock);
        req_valid = 1'b0;
    endtask

    initial begin
        int cnt;
        int target;
        int cyc;

        // Request held during reset must not be accepted.
        req_valid = 1'b1; req_src = 3'd1; req_dst = 3'd2;
        repeat (3) @(negedge bus_clock);
        check("rst_ready",   req_ready, 1);
        check("rst_out_en",  reg_out_en, 0);
        check("rst_in_en",   reg_in_en, 0);
        check("rst_imm_out", imm_out_en, 0);
        check("rst_imm_data", bus_imm_data, 0);
        check("rst_sample",  bus_sample, 0);
        check("rst_done",    xfer_done, 0);
        check("rst_err",     xfer_err, 0);
        req_valid = 1'b0; bus_reset_n = 1'b1;
        @(negedge bus_clock);

        // Register move 2 -> 5.
        request(3'd2, 3'd5, 1'b0, 16'h0);
        check("mv_c1_out", reg_out_en, 8'b0000_0100);
        check("mv_c1_in",  reg_in_en, 8'b0);
        check("mv_c1_rdy", req_ready, 0);
        bus_data = 16'hA5A5;
        @(negedge bus_clock);
        check("mv_c2_out", reg_out_en, 8'b0000_0100);
        check("mv_c2_in",  reg_in_en, 8'b0010_0000);
        check("mv_c2_rdy", req_ready, 0);
        @(negedge bus_clock);
        check("mv_c3_done",   xfer_done, 1);
        check("mv_c3_err",    xfer_err, 0);
        check("mv_c3_sample", bus_sample, 16'hA5A5);
        check("mv_c3_out",    reg_out_en, 0);
        check("mv_c3_rdy",    req_ready, 0);
        @(negedge bus_clock);
        check("mv_idle_rdy",  req_ready, 1);
        check("mv_idle_done", xfer_done, 0);

        // Immediate 0x1234 -> r0.
        request(3'd7, 3'd0, 1'b1, 16'h1234);
        check("imm_c1_imm",  imm_out_en, 1);
        check("imm_c1_out",  reg_out_en, 0);
        check("imm_c1_in",   reg_in_en, 0);
        check("imm_c1_data", bus_imm_data, 16'h1234);
        @(negedge bus_clock);
        check("imm_c2_imm",  imm_out_en, 1);
        check("imm_c2_in",   reg_in_en, 8'b0000_0001);
        check("imm_c2_out",  reg_out_en, 0);
        @(negedge bus_clock);
        check("imm_c3_done", xfer_done, 1);
        check("imm_c3_imm",  imm_out_en, 0);
        @(negedge bus_clock);
        check("imm_idle_rdy", req_ready, 1);

        // src == dst error.
        request(3'd3, 3'd3, 1'b0, 16'h0);
        check("e1_done", xfer_done, 1);
        check("e1_err",  xfer_err, 1);
        check("e1_out",  reg_out_en, 0);
        check("e1_in",   reg_in_en, 0);
        check("e1_imm",  imm_out_en, 0);
        @(negedge bus_clock);
        check("e1_rdy",  req_ready, 1);
        check("e1_done_low", xfer_done, 0);

        // dst beyond a 4-register instance; the 8-register instance treats it as valid.
        request(3'd1, 3'd6, 1'b0, 16'h0);
        check("e4_done", d4_done, 1);
        check("e4_err",  d4_err, 1);
        check("e4_out",  d4_out_en, 0);
        check("e4_in",   d4_in_en, 0);
        check("e4_main_out", reg_out_en, 8'b0000_0010);
        @(negedge bus_clock);
        check("e4_rdy", d4_ready, 1);
        wait_ready();

        // Back-to-back with req_valid held: 1 -> 2 then 2 -> 7.
        req_src = 3'd1; req_dst = 3'd2; req_imm_en = 1'b0; req_valid = 1'b1;
        @(negedge bus_clock);
        check("b2b_first_out", reg_out_en, 8'b0000_0010);
        req_src = 3'd2; req_dst = 3'd7;
        cnt = 1;
        while (!req_ready && cnt < 10) begin
            @(negedge bus_clock);
            cnt++;
        end
        check("b2b_gap", cnt, 4);
        @(negedge bus_clock);
        req_valid = 1'b0;
        check("b2b_second_out", reg_out_en, 8'b0000_0100);
        check("b2b_second_rdy", req_ready, 0);
        wait_ready();

        // Reset during DRIVE.
        request(3'd0, 3'd4, 1'b1, 16'hBEEF);
        check("rmid_imm_data", bus_imm_data, 16'hBEEF);
        check("rmid_imm_out",  imm_out_en, 1);
        bus_reset_n = 1'b0;
        @(negedge bus_clock);
        check("rmid_out",  reg_out_en, 0);
        check("rmid_in",   reg_in_en, 0);
        check("rmid_imm",  imm_out_en, 0);
        check("rmid_rdy",  req_ready, 1);
        check("rmid_done", xfer_done, 0);
        check("rmid_data", bus_imm_data, 0);
        bus_reset_n = 1'b1;
        @(negedge bus_clock);

        // Random traffic with occasional resets.
        target = m_accepts + 1000;
        cyc = 0;
        while (m_accepts < target && cyc < 20000) begin
            @(negedge bus_clock);
            cyc++;
            req_valid   = ($urandom_range(0, 9) < 7);
            req_src     = 3'($urandom_range(0, 7));
            req_dst     = 3'($urandom_range(0, 7));
            req_imm_en  = ($urandom_range(0, 3) == 0);
            req_imm     = DW'($urandom);
            bus_data    = DW'($urandom);
            bus_reset_n = ($urandom_range(0, 299) != 0);
        end
        check("rand_accepts", m_accepts >= target, 1);
        req_valid = 1'b0; bus_reset_n = 1'b1;
        repeat (5) @(negedge bus_clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
